// File: rtl/multi_timer_if.sv
// multi_timer bus: control/config from the host side,
// count, compare outputs and status back from the timer.
interface multi_timer_if #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int PRE_W    = 8
);
  logic                      en;
  logic [1:0]                mode;
  logic                      start;
  logic [PRE_W-1:0]          prescale;
  logic [WIDTH-1:0]          tmr_period;
  logic [CHANNELS*WIDTH-1:0] tmr_compare;
  logic                      flag_clr;
  logic [WIDTH-1:0]          tmr_count;
  logic [CHANNELS-1:0]       cmp_out;
  logic                      period_flag;
  logic                      running;

  modport master (
    output en, mode, start, prescale,
    output tmr_period, tmr_compare, flag_clr,
    input  tmr_count, cmp_out,
    input  period_flag, running
  );

  modport slave (
    input  en, mode, start, prescale,
    input  tmr_period, tmr_compare, flag_clr,
    output tmr_count, cmp_out,
    output period_flag, running
  );
endinterface

// File: rtl/multi_timer.sv
// Shared-counter multi-channel timer/PWM with prescaler,
// up / up-down / one-shot modes and double-buffered config.
module multi_timer #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int PRE_W    = 8
) (
  input logic           clk,
  input logic           rst,
  multi_timer_if.slave  bus
);
  localparam logic [1:0] M_UP = 2'd0;
  localparam logic [1:0] M_UD = 2'd1;
  localparam logic [1:0] M_OS = 2'd2;

  logic [WIDTH-1:0]          count;
  logic [WIDTH-1:0]          period_sh;
  logic [CHANNELS*WIDTH-1:0] compare_sh;
  logic [1:0]                mode_sh;
  logic [PRE_W-1:0]          pre_cnt;
  logic                      dir_dn;
  logic                      flag;
  logic                      os_run;

  logic [1:0]       mode_in;
  logic             active;
  logic             tick;
  logic             running;
  logic             upd;
  logic             set_flag;
  logic [WIDTH-1:0] cnt_nx;
  logic             dir_nx;
  logic             run_nx;

  assign mode_in = (bus.mode == 2'd3) ? M_UP : bus.mode;
  assign active  = (mode_sh == M_OS) ? os_run : 1'b1;
  assign tick    = bus.en & active & (pre_cnt == bus.prescale);
  assign running = rst & ((mode_sh == M_OS) ? os_run : bus.en);

  always_comb begin
    upd      = 1'b0;
    set_flag = 1'b0;
    cnt_nx   = count;
    dir_nx   = dir_dn;
    run_nx   = os_run;
    unique case (mode_sh)
      M_UD: begin
        if (tick) begin
          if (!dir_dn) begin
            if (count == period_sh) begin
              set_flag = 1'b1;
              if (period_sh == '0) begin
                upd = 1'b1;
              end else begin
                dir_nx = 1'b1;
                cnt_nx = count - 1'b1;
              end
            end else begin
              cnt_nx = count + 1'b1;
            end
          end else if (count == '0) begin
            upd    = 1'b1;
            dir_nx = 1'b0;
            cnt_nx = (bus.tmr_period == '0) ? '0 : WIDTH'(1);
          end else begin
            cnt_nx = count - 1'b1;
          end
        end
      end
      M_OS: begin
        if (!os_run) begin
          if (bus.start) begin
            upd    = 1'b1;
            run_nx = 1'b1;
            cnt_nx = '0;
          end
        end else if (tick) begin
          if (count == period_sh) begin
            cnt_nx   = '0;
            run_nx   = 1'b0;
            set_flag = 1'b1;
          end else begin
            cnt_nx = count + 1'b1;
          end
        end
      end
      default: begin
        if (tick) begin
          if (count == period_sh) begin
            cnt_nx   = '0;
            upd      = 1'b1;
            set_flag = 1'b1;
          end else begin
            cnt_nx = count + 1'b1;
          end
        end
      end
    endcase
    // a new mode always begins from a clean, idle, upward state
    if (upd && (mode_in != mode_sh)) begin
      cnt_nx = '0;
      dir_nx = 1'b0;
      run_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      pre_cnt    <= '0;
      dir_dn     <= 1'b0;
      flag       <= 1'b0;
      os_run     <= 1'b0;
      period_sh  <= bus.tmr_period;
      compare_sh <= bus.tmr_compare;
      mode_sh    <= mode_in;
    end else if (bus.en) begin
      count  <= cnt_nx;
      dir_dn <= dir_nx;
      os_run <= run_nx;
      if (upd) begin
        pre_cnt    <= '0;
        period_sh  <= bus.tmr_period;
        compare_sh <= bus.tmr_compare;
        mode_sh    <= mode_in;
      end else if (active) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
      if (set_flag) begin
        flag <= 1'b1;
      end else if (bus.flag_clr) begin
        flag <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
    assign bus.cmp_out[i] =
      running & (count < compare_sh[i*WIDTH +: WIDTH]);
  end

  assign bus.tmr_count   = count;
  assign bus.period_flag = flag;
  assign bus.running     = running;
endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: stimulus queues expected
// per-edge state, a monitor pops and compares after each edge.
module tb_multi_timer;
  localparam int W  = 24;
  localparam int CH = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_timer_if #(.WIDTH(W), .CHANNELS(CH), .PRE_W(PW)) bus();

  multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            cyc;
    string         nm;
    logic [W-1:0]  cnt;
    logic [CH-1:0] cmp;
    logic          flag;
    logic          run;
  } exp_t;

  exp_t sb[$];
  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] cin [CH];
  logic [W-1:0] csh [CH];

  bit os_st  [12] = '{0,1,0,0,1,0,0,0,0,0,1,0};
  bit os_clr [12] = '{0,0,0,0,0,0,0,1,0,1,0,0};
  int os_cnt [12] = '{0,0,1,2,3,4,5,0,0,0,0,1};
  bit os_run [12] = '{0,1,1,1,1,1,1,0,0,0,1,1};
  bit os_flg [12] = '{0,0,0,0,0,0,0,1,1,0,0,0};

  function automatic logic [CH-1:0] cmpv(
    input logic [W-1:0] c, input logic r);
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = r && (c < csh[i]);
    return v;
  endfunction

  task automatic drive_cmp();
    bus.tmr_compare = {cin[3], cin[2], cin[1], cin[0]};
  endtask

  task automatic chk(input logic [W-1:0] c, input logic f,
                     input logic r, input string nm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.nm   = nm;
    e.cnt  = c;
    e.cmp  = cmpv(c, r);
    e.flag = f;
    e.run  = r;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] m,
                          input logic [W-1:0] p,
                          input logic [PW-1:0] ps,
                          input logic [W-1:0] c0);
    rst             = 1'b0;
    bus.en          = 1'b1;
    bus.mode        = m;
    bus.tmr_period  = p;
    bus.prescale    = ps;
    bus.start       = 1'b0;
    bus.flag_clr    = 1'b0;
    cin[0] = c0;
    cin[1] = '0;
    cin[2] = W'(100);
    cin[3] = W'(2);
    drive_cmp();
    for (int i = 0; i < CH; i++) csh[i] = cin[i];
    chk('0, 1'b0, 1'b0, "reset");
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != cyc || bus.tmr_count !== e.cnt ||
            bus.cmp_out !== e.cmp || bus.period_flag !== e.flag ||
            bus.running !== e.run) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got cnt=%0d cmp=%b flag=%b run=%b, want cnt=%0d cmp=%b flag=%b run=%b",
                   e.nm, cyc, bus.tmr_count, bus.cmp_out,
                   bus.period_flag, bus.running,
                   e.cnt, e.cmp, e.flag, e.run);
        end
      end
    end
  end

  initial begin : stim
    logic fl;
    int   n;
    int   m;
    @(negedge clk);

    // up mode, P=7, C0 updates land only at the wrap
    do_reset(2'd0, W'(7), '0, W'(4));
    fl = 1'b0;
    for (int k = 1; k <= 47; k++) begin
      if (k == 19) cin[0] = W'(1);
      if (k == 27) cin[0] = '0;
      if (k == 35) cin[0] = W'(8);
      drive_cmp();
      bus.flag_clr = (k == 21);
      if (k % 8 == 0) begin
        csh[0] = cin[0];
        fl     = 1'b1;
      end else if (k == 21) begin
        fl = 1'b0;
      end
      chk(W'(k % 8), fl, 1'b1, "up");
    end
    bus.flag_clr = 1'b0;

    // prescale 2, P=3, en dropped for 5 cycles
    do_reset(2'd0, W'(3), PW'(2), W'(2));
    n = 0;
    for (int j = 1; j <= 30; j++) begin
      bus.en = !(j >= 5 && j <= 9);
      if (bus.en) n++;
      chk(W'((n / 3) % 4), n >= 12, bus.en, "presc");
    end
    bus.en = 1'b1;

    // up/down, P=4, then reset in the down phase
    do_reset(2'd1, W'(4), '0, W'(2));
    for (int k = 1; k <= 22; k++) begin
      m = k % 8;
      chk(W'((m <= 4) ? m : 8 - m), k >= 5, 1'b1, "updown");
    end
    rst = 1'b0;
    chk('0, 1'b0, 1'b0, "rst_mid");
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      m = k % 8;
      chk(W'((m <= 4) ? m : 8 - m), k >= 5, 1'b1, "ud_restart");
    end

    // one-shot, P=5
    do_reset(2'd2, W'(5), '0, W'(3));
    for (int k = 0; k < 12; k++) begin
      bus.start    = os_st[k];
      bus.flag_clr = os_clr[k];
      chk(W'(os_cnt[k]), os_flg[k], os_run[k], "oneshot");
    end
    bus.start    = 1'b0;
    bus.flag_clr = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel timer/PWM generator for the display board, succeeding the single-compare timer. One shared counter with prescaler drives CHANNELS compare outputs (brightness and multiplex-strobe generation). Supports up-count, up/down (centre-aligned) and one-shot modes. Period, compare and mode are double-buffered so software-side changes never glitch an output mid-cycle.

## Interface
- WIDTH, 24: counter, period and compare width
- CHANNELS, 4: number of compare channels
- PRE_W, 8: prescaler width

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-low reset
- en  in  1  count enable; low freezes prescaler and counter
- mode  in  2  0 = up, 1 = up/down, 2 = one-shot, 3 = treated as 0
- start  in  1  one-shot trigger pulse
- prescale  in  PRE_W  counter advances every prescale+1 enabled cycles
- tmr_period  in  WIDTH  terminal count
- tmr_compare  in  CHANNELS*WIDTH  channel i compare at [i*WIDTH +: WIDTH]
- flag_clr  in  1  clears period_flag
- tmr_count  out  WIDTH  current count
- cmp_out  out  CHANNELS  compare outputs
- period_flag  out  1  sticky period-event flag
- running  out  1  counter active

## Operation
- Reset (rst low at an edge): count 0, prescaler 0, direction up, period_flag 0, running 0; shadow period/compare/mode load from inputs every reset cycle. cmp_out forced 0 while rst low.
- tick: pre_cnt == prescale with en high and counter active; pre_cnt then returns to 0, else increments. prescale 0 → tick every enabled cycle. prescale is not shadowed.
- Update event: shadow period, compare and mode reload from inputs. Between events, input changes have no effect on counting or outputs.
- Up (mode 0): on tick, count == period_sh → count 0, update event, set period_flag; else count+1. running = en.
- Up/down (mode 1): up phase: count == period_sh → set period_flag, direction down, count−1 (period_sh 0: stay 0, update event). Down phase: count == 0 → update event, direction up, count+1; else count−1. running = en.
- One-shot (mode 2): idle (running 0, count 0) until start high with en high; next edge running 1, update event at that edge. Ticks count up; on tick at count == period_sh: count 0, running 0, period_flag set. start while running ignored.
- Mode taking effect at an update event starts from count 0, direction up.
- cmp_out[i] = running & (tmr_count < compare_sh[i]), unsigned. compare 0 → always low; compare > period → always high while running.
- period_flag: set wins over simultaneous flag_clr.
- en low: everything holds, including direction and flag.

## Timing
- Counter, flags, running registered; cmp_out combinational from registered count/shadow/running (no extra latency).
- tick at edge k → new tmr_count visible after edge k.
- Up mode, prescale 0: sequence 0..P repeats every P+1 cycles; period_flag high from the edge that wraps P → 0.
- Up/down: full cycle 2P cycles at prescale 0; flag at top.
- Input change at any cycle before the wrap edge takes effect at that wrap edge; changes after it wait a full period.
- Reset mid-operation: all state returns to reset values on the next edge regardless of mode/phase.

## Test plan
- Up, P=7, C0=4, prescale 0, en 1 after reset → count 0..7 repeating; cmp_out[0] high at counts 0–3, low at 4–7; period_flag set at first wrap.
- Change C0 to 1, then 0, then 8 mid-period → each takes effect only at next wrap; 1 → high at count 0 only; 0 → never high; 8 → constantly high.
- Prescale 2, P=3 → count steps every 3 cycles, period 12 cycles; en low 5 cycles mid-count → count and pre_cnt frozen, resume with no lost tick.
- Up/down, P=4, C0=2 → count 0,1,2,3,4,3,2,1,0,1…; cmp_out[0] high at counts 0–1 on both slopes; period_flag at count 4.
- One-shot, P=5 → start pulse gives count 0..5 then 0, running low, period_flag set; second start during run ignored; flag_clr on same cycle as set → flag stays 1.
- rst low mid-count in up/down down phase → next edge count 0, running 0, flag 0, cmp_out 0; after release counts up from 0.
